// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: loads one input matrix, runs the MAC array for a full pass and writes
// each result group to the result RAM; a compute watchdog parks the controller in ERR.
module mac_array_ctrl #(
  parameter int LOAD_WORDS  = 8,
  parameter int RES_PER_MAT = 4,
  parameter int AW          = 4,
  parameter int TIMEOUT     = 40
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_clear_err,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  output logic                          o_load_en,
  output logic [$clog2(LOAD_WORDS)-1:0] o_load_cnt,
  output logic                          o_alu_en,
  input  logic                          i_alu_web,
  input  logic                          i_alu_done,
  output logic                          o_ram_we,
  output logic [AW-1:0]                 o_ram_addr,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err
);

  localparam int LCW = $clog2(LOAD_WORDS);
  localparam int WCW = $clog2(RES_PER_MAT + 1);
  localparam int WDW = $clog2(TIMEOUT);

  localparam logic [LCW-1:0] LD_LAST   = LCW'(LOAD_WORDS - 1);
  localparam logic [WCW-1:0] WR_MAX    = WCW'(RES_PER_MAT);
  localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [AW-1:0]  BASE_STEP = AW'(RES_PER_MAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_FINISH  = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [LCW-1:0] r_ld_cnt;
  logic [WCW-1:0] r_wr_cnt;
  logic [WDW-1:0] r_wd;
  logic [AW-1:0]  r_base;
  logic           r_in_ready;
  logic           r_alu_en;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic           w_load_en;
  logic           w_ram_we;
  logic           w_wd_expired;

  // Write strobes stay combinational so a beat or result group is taken in its own cycle.
  assign w_load_en    = r_in_ready & i_in_valid;
  assign w_ram_we     = (r_state == S_COMPUTE) & i_alu_web & (r_wr_cnt < WR_MAX);
  assign w_wd_expired = (r_wd == WD_LAST);

  // Next-state decode; alu_done is tested before the watchdog so a late pass still finishes.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_load_en && (r_ld_cnt == LD_LAST)) begin
          w_next_state = S_COMPUTE;
        end else begin
          w_next_state = S_LOAD;
        end
      end
      S_COMPUTE: begin
        if (i_alu_done) begin
          w_next_state = S_FINISH;
        end else if (w_wd_expired) begin
          w_next_state = S_ERR;
        end else begin
          w_next_state = S_COMPUTE;
        end
      end
      S_FINISH: begin
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        if (i_clear_err) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ERR;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register plus status flags registered from the next state, so they track r_state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_alu_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_LOAD);
      r_alu_en   <= (w_next_state == S_COMPUTE);
      r_busy     <= (w_next_state != S_IDLE);
      r_done     <= (w_next_state == S_FINISH);
      r_err      <= (w_next_state == S_ERR);
    end
  end

  // Load/write counters, watchdog and the rolling result base address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ld_cnt <= '0;
      r_wr_cnt <= '0;
      r_wd     <= '0;
      r_base   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ld_cnt <= '0;
          r_wr_cnt <= '0;
          r_wd     <= '0;
        end
        S_LOAD: begin
          if (w_load_en) begin
            r_ld_cnt <= (r_ld_cnt == LD_LAST) ? '0 : r_ld_cnt + LCW'(1);
          end
        end
        S_COMPUTE: begin
          r_wd <= r_wd + WDW'(1);
          if (w_ram_we) begin
            r_wr_cnt <= r_wr_cnt + WCW'(1);
          end
        end
        S_FINISH: begin
          r_base <= r_base + BASE_STEP;
        end
        default: begin
          r_base <= r_base;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_load_en  = w_load_en;
  assign o_load_cnt = r_ld_cnt;
  assign o_alu_en   = r_alu_en;
  assign o_ram_we   = w_ram_we;
  assign o_ram_addr = r_base + AW'(r_wr_cnt);
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

endmodule
